// File: rtl/seq_mag_cmp_ctrl_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// The state encoding is fixed so that the unused code 2'd3 falls back to IDLE.
package seq_mag_cmp_ctrl_pkg;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Index width for WIDTH/2 digit pairs, never narrower than one bit.
   function automatic int unsigned calc_idxw(input int unsigned width);
      return (width / 2 <= 2) ? 1 : $clog2(width / 2);
   endfunction

endpackage

// File: rtl/seq_mag_cmp_ctrl_cmp_slice2.sv
// Combinational 2-bit unsigned compare slice, time-shared by the sequencer.
module cmp_slice2 (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic       gt,
   output logic       eq
);

   assign gt = (x > y);
   assign eq = (x == y);

endmodule

// File: rtl/seq_mag_cmp_ctrl.sv
// Unsigned magnitude comparator that walks 2-bit digit pairs MSB-first through a
// single shared slice, stopping at the first unequal pair.
module seq_mag_cmp_ctrl
   import seq_mag_cmp_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned IDXW  = calc_idxw(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             equal,
   output logic             greater,
   output logic             answer,
   output logic [IDXW:0]    slices_used
);

   localparam int unsigned    N       = WIDTH / 2;
   localparam logic [IDXW-1:0] IDX_TOP = IDXW'(N - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDXW-1:0]  r_idx;
   logic [IDXW:0]    r_cnt;
   logic             r_equal;
   logic             r_greater;
   logic             r_answer;
   logic [IDXW:0]    r_slices;

   logic [1:0]       w_x;
   logic [1:0]       w_y;
   logic             w_gt;
   logic             w_eq;
   logic [IDXW:0]    w_cnt_nxt;

   // Digit mux: select pair idx from the captured operands.
   assign w_x       = r_a[{r_idx, 1'b0} +: 2];
   assign w_y       = r_b[{r_idx, 1'b0} +: 2];
   assign w_cnt_nxt = r_cnt + (IDXW + 1)'(1);

   cmp_slice2 u_slice (
      .x  (w_x),
      .y  (w_y),
      .gt (w_gt),
      .eq (w_eq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_equal   <= 1'b0;
         r_greater <= 1'b0;
         r_answer  <= 1'b0;
         r_slices  <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_idx   <= IDX_TOP;
                  r_cnt   <= '0;
                  r_state <= COMPARE;
               end else begin
                  r_state <= IDLE;
               end
            end
            COMPARE: begin
               r_cnt <= w_cnt_nxt;
               if (w_gt) begin
                  r_greater <= 1'b1;
                  r_equal   <= 1'b0;
                  r_answer  <= 1'b1;
                  r_slices  <= w_cnt_nxt;
                  r_state   <= DONE;
               end else if (!w_eq) begin
                  r_greater <= 1'b0;
                  r_equal   <= 1'b0;
                  r_answer  <= 1'b0;
                  r_slices  <= w_cnt_nxt;
                  r_state   <= DONE;
               end else if (r_idx == '0) begin
                  r_greater <= 1'b0;
                  r_equal   <= 1'b1;
                  r_answer  <= 1'b1;
                  r_slices  <= w_cnt_nxt;
                  r_state   <= DONE;
               end else begin
                  r_idx <= r_idx - IDXW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy        = (r_state == COMPARE);
   assign done        = (r_state == DONE);
   assign equal       = r_equal;
   assign greater     = r_greater;
   assign answer      = r_answer;
   assign slices_used = r_slices;

endmodule

// File: tb/tb_seq_mag_cmp_ctrl.sv
// Self-checking bench: directed cases plus randomized traffic against a
// cycle-level behavioural model of the comparator.
module tb_seq_mag_cmp_ctrl;

   localparam int W = 8;
   localparam int N = W / 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, equal, greater, answer;
   logic [2:0]   slices_used;

   int checks = 0;
   int failures = 0;

   seq_mag_cmp_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .equal       (equal),
      .greater     (greater),
      .answer      (answer),
      .slices_used (slices_used)
   );

   always #5 clk = ~clk;

   // Number of digit pairs examined: MSB-first up to and including the first differing pair.
   function automatic int exp_slices(input logic [W-1:0] x, input logic [W-1:0] y);
      int c;
      c = 0;
      for (int i = N - 1; i >= 0; i--) begin
         c++;
         if (x[2*i +: 2] != y[2*i +: 2]) break;
      end
      return c;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: remaining compare cycles plus committed results.
   int m_rem = 0;
   bit m_done = 0;
   bit m_eq = 0, m_gt = 0;
   int m_sl = 0;
   bit p_eq = 0, p_gt = 0;
   int p_sl = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem  <= 0;
         m_done <= 0;
         m_eq   <= 0;
         m_gt   <= 0;
         m_sl   <= 0;
      end else if (m_rem != 0) begin
         m_rem  <= m_rem - 1;
         m_done <= (m_rem == 1);
         if (m_rem == 1) begin
            m_eq <= p_eq;
            m_gt <= p_gt;
            m_sl <= p_sl;
         end
      end else begin
         m_done <= 0;
         if (start) begin
            m_rem <= exp_slices(a, b);
            p_sl  <= exp_slices(a, b);
            p_eq  <= (a == b);
            p_gt  <= (a > b);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc_busy", int'(busy), int'(m_rem != 0));
         check("cyc_done", int'(done), int'(m_done));
         check("cyc_equal", int'(equal), int'(m_eq));
         check("cyc_greater", int'(greater), int'(m_gt));
         check("cyc_answer", int'(answer), int'(m_eq | m_gt));
         check("cyc_slices", int'(slices_used), m_sl);
      end
   end

   // Issue one request from a post-edge point and wait (bounded) for done.
   task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input int ek,
                     input bit eg, input bit ee, input string nm, output int busy_cnt);
      int n;
      start = 1'b1;
      a = ia;
      b = ib;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      busy_cnt = int'(busy);
      n = 0;
      for (int i = 1; i <= N + 2; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n = i;
            break;
         end
         busy_cnt += int'(busy);
      end
      check({nm, "_latency"}, n, ek);
      check({nm, "_greater"}, int'(greater), int'(eg));
      check({nm, "_equal"}, int'(equal), int'(ee));
      check({nm, "_answer"}, int'(answer), int'(eg | ee));
      check({nm, "_slices"}, int'(slices_used), ek);
   endtask

   initial begin
      int bc;
      logic [W-1:0] mask;

      check("model_c0_80", exp_slices(8'hC0, 8'h80), 1);
      check("model_96_96", exp_slices(8'h96, 8'h96), 4);
      check("model_12_13", exp_slices(8'h12, 8'h13), 4);

      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_slices", int'(slices_used), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      op(8'hC0, 8'h80, 1, 1'b1, 1'b0, "c0_80", bc);
      op(8'h96, 8'h96, 4, 1'b0, 1'b1, "96_96", bc);
      check("96_96_busy_cycles", bc, 4);
      op(8'h12, 8'h13, 4, 1'b0, 1'b0, "12_13", bc);
      @(posedge clk);
      #1;

      // Start while busy is ignored.
      start = 1'b1;
      a = 8'h40;
      b = 8'h3F;
      @(posedge clk);
      #1;
      a = 8'h00;
      b = 8'hFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("ign_done", int'(done), 1);
      check("ign_greater", int'(greater), 1);
      check("ign_slices", int'(slices_used), 1);
      @(posedge clk);
      #1;
      check("ign_no_restart", int'(busy), 0);

      // Asynchronous reset in the middle of a compare.
      start = 1'b1;
      a = 8'h55;
      b = 8'h55;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_busy", int'(busy), 0);
      check("arst_done", int'(done), 0);
      check("arst_equal", int'(equal), 0);
      check("arst_greater", int'(greater), 0);
      check("arst_answer", int'(answer), 0);
      check("arst_slices", int'(slices_used), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      op(8'h01, 8'h00, 4, 1'b1, 1'b0, "post_rst", bc);
      @(posedge clk);
      #1;

      // Back-to-back with start held high.
      start = 1'b1;
      a = 8'hF0;
      b = 8'h0F;
      @(posedge clk);
      #1;
      a = 8'h0F;
      b = 8'hF0;
      @(posedge clk);
      #1;
      check("b2b_done1", int'(done), 1);
      check("b2b_greater1", int'(greater), 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_busy", int'(busy), 1);
      check("b2b_nodone", int'(done), 0);
      @(posedge clk);
      #1;
      check("b2b_done2", int'(done), 1);
      check("b2b_greater2", int'(greater), 0);
      check("b2b_answer2", int'(answer), 0);
      check("b2b_slices2", int'(slices_used), 1);

      // Random traffic; b shares a random number of top bits with a.
      for (int i = 0; i < 500; i++) begin
         start = ($urandom_range(0, 3) != 0);
         a = W'($urandom);
         mask = 8'hFF >> $urandom_range(0, 8);
         b = a ^ (W'($urandom) & mask);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      repeat (N + 2) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
